// File: rtl/pb_pkg.sv
// Shared types for the protobuf varint decode path: decode modes, error codes,
// wire types and FSM states, plus small helpers used by the stream decoder.
package pb_pkg;

    typedef enum logic [1:0] {
        PB_MODE_RAW    = 2'd0,
        PB_MODE_ZIGZAG = 2'd1,
        PB_MODE_KEY    = 2'd2
    } pb_varint_mode_e;

    typedef enum logic [1:0] {
        PB_ERR_OK       = 2'd0,
        PB_ERR_OVERFLOW = 2'd1,
        PB_ERR_TRUNC    = 2'd2,
        PB_ERR_BAD_WIRE = 2'd3
    } pb_dec_err_e;

    typedef enum logic [2:0] {
        WIRE_VARINT = 3'd0,
        WIRE_I64    = 3'd1,
        WIRE_LEN    = 3'd2,
        WIRE_SGROUP = 3'd3,
        WIRE_EGROUP = 3'd4,
        WIRE_I32    = 3'd5
    } wire_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } pb_dec_state_e;

    localparam int MAX_VARINT_BYTES = 10;

    // The reserved encoding 3 decodes as RAW.
    function automatic pb_varint_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return PB_MODE_ZIGZAG;
            2'd2:    return PB_MODE_KEY;
            default: return PB_MODE_RAW;
        endcase
    endfunction

    function automatic logic is_bad_wire(input logic [2:0] w);
        return w > WIRE_I32;
    endfunction

endpackage

// File: rtl/pb_zigzag_decode.sv
// Combinational zigzag-to-two's-complement conversion for sint32/sint64 fields.
module pb_zigzag_decode #(
    parameter int VALUE_W = 64
) (
    input  logic [VALUE_W-1:0] raw,
    output logic [VALUE_W-1:0] value
);

    assign value = (raw >> 1) ^ {VALUE_W{raw[0]}};

endmodule

// File: rtl/pb_varint_stream_decoder.sv
// Byte-stream protobuf varint decoder: one byte per cycle in, one decoded word
// per varint out, with overflow / truncation / wire-type error reporting.
module pb_varint_stream_decoder
    import pb_pkg::*;
#(
    parameter int VALUE_W   = 64,
    parameter int MAX_BYTES = (VALUE_W == 64) ? MAX_VARINT_BYTES : (VALUE_W + 6) / 7,
    parameter int FIELD_W   = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VALUE_W-1:0] out_value,
    output logic [FIELD_W-1:0] out_field,
    output logic [2:0]         out_wire,
    output logic [3:0]         out_nbytes,
    output logic [1:0]         out_err
);

    localparam int KEY_W = FIELD_W + 3;

    pb_dec_state_e   state_q, state_d;
    pb_varint_mode_e mode_q, mode_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [3:0]         count_q, count_d;

    logic               out_valid_q, out_valid_d;
    logic [VALUE_W-1:0] out_value_q, out_value_d;
    logic [FIELD_W-1:0] out_field_q, out_field_d;
    logic [2:0]         out_wire_q, out_wire_d;
    logic [3:0]         out_nbytes_q, out_nbytes_d;
    pb_dec_err_e        out_err_q, out_err_d;

    logic               accept;
    pb_varint_mode_e    cur_mode;
    logic [3:0]         count_inc;
    int                 shamt;
    logic [VALUE_W+6:0] wide;
    logic [VALUE_W-1:0] acc_new;
    logic [VALUE_W-1:0] zz_value;
    logic [KEY_W-1:0]   key;
    logic               overflow;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cur_mode = (state_q == ST_IDLE) ? decode_mode(mode) : mode_q;
    assign count_inc = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;

    // Payload bits landing at or above VALUE_W fall into the top 7 bits of wide.
    assign shamt    = 7 * int'(count_q);
    assign wide     = {{VALUE_W{1'b0}}, in_data[6:0]} << shamt;
    assign acc_new  = acc_q | wide[VALUE_W-1:0];
    assign overflow = (count_q == 4'(MAX_BYTES - 1) && in_data[7]) || (|wide[VALUE_W+6:VALUE_W]);

    generate
        if (VALUE_W >= KEY_W) begin : g_key_slice
            assign key = acc_new[KEY_W-1:0];
        end else begin : g_key_pad
            assign key = {{(KEY_W - VALUE_W){1'b0}}, acc_new};
        end
    endgenerate

    pb_zigzag_decode #(.VALUE_W(VALUE_W)) u_zigzag (
        .raw   (acc_new),
        .value (zz_value)
    );

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= PB_MODE_RAW;
            acc_q        <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_field_q  <= '0;
            out_wire_q   <= '0;
            out_nbytes_q <= '0;
            out_err_q    <= PB_ERR_OK;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_field_q  <= out_field_d;
            out_wire_q   <= out_wire_d;
            out_nbytes_q <= out_nbytes_d;
            out_err_q    <= out_err_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d      = state_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_value_d  = out_value_q;
        out_field_d  = out_field_q;
        out_wire_d   = out_wire_q;
        out_nbytes_d = out_nbytes_q;
        out_err_d    = out_err_q;

        if (accept) begin
            count_d = count_inc;
            if (state_q == ST_DRAIN) begin
                if (!in_data[7] || in_last) begin
                    state_d      = ST_IDLE;
                    acc_d        = '0;
                    count_d      = '0;
                    out_valid_d  = 1'b1;
                    out_value_d  = '0;
                    out_field_d  = '0;
                    out_wire_d   = '0;
                    out_nbytes_d = count_inc;
                    out_err_d    = PB_ERR_OVERFLOW;
                end
            end else begin
                mode_d  = cur_mode;
                acc_d   = acc_new;
                state_d = ST_ACCUM;
                if (overflow) begin
                    if (in_data[7] && !in_last) begin
                        state_d = ST_DRAIN;
                        acc_d   = '0;
                    end else begin
                        state_d      = ST_IDLE;
                        acc_d        = '0;
                        count_d      = '0;
                        out_valid_d  = 1'b1;
                        out_value_d  = '0;
                        out_field_d  = '0;
                        out_wire_d   = '0;
                        out_nbytes_d = count_inc;
                        out_err_d    = PB_ERR_OVERFLOW;
                    end
                end else if (!in_data[7] || in_last) begin
                    // Normal termination, or truncation reporting the partial accumulator.
                    state_d      = ST_IDLE;
                    acc_d        = '0;
                    count_d      = '0;
                    out_valid_d  = 1'b1;
                    out_value_d  = acc_new;
                    out_field_d  = '0;
                    out_wire_d   = '0;
                    out_nbytes_d = count_inc;
                    out_err_d    = in_data[7] ? PB_ERR_TRUNC : PB_ERR_OK;
                    if (cur_mode == PB_MODE_ZIGZAG && !in_data[7]) begin
                        out_value_d = zz_value;
                    end
                    if (cur_mode == PB_MODE_KEY) begin
                        out_field_d = key[KEY_W-1:3];
                        out_wire_d  = key[2:0];
                        if (!in_data[7] && (is_bad_wire(key[2:0]) || key[KEY_W-1:3] == '0)) begin
                            out_err_d = PB_ERR_BAD_WIRE;
                        end
                    end
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_value  = out_value_q;
    assign out_field  = out_field_q;
    assign out_wire   = out_wire_q;
    assign out_nbytes = out_nbytes_q;
    assign out_err    = out_err_q;

endmodule

// File: doc/pb_varint_stream_decoder.md
Name: pb_varint_stream_decoder

Overview:
Hardware streaming decoder for protobuf base-128 varints. It consumes one byte per cycle from a valid/ready byte stream and emits one decoded word per varint. A per-varint mode selects raw unsigned, zigzag-signed (sint32/sint64) or message-key decode (field number and wire type). It sits between the byte-stream ingress and the field-dispatch logic, and adds overflow, truncation and wire-type error reporting that the software decode helpers lack.

Parameters:
VALUE_W, 64, decoded value width in bits; legal range 8..64.
MAX_BYTES, (VALUE_W+6)/7, maximum encoded bytes accepted before overflow; 10 for VALUE_W=64.
FIELD_W, 29, field-number width in key mode.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid&&in_ready
in_data  in  8  encoded byte; bit7 = continuation
in_last  in  1  final byte of stream/segment
mode  in  2  0=RAW, 1=ZIGZAG, 2=KEY, 3=reserved (treated as RAW); sampled with first byte of each varint
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_value  out  VALUE_W  decoded value (RAW/ZIGZAG), or full key varint (KEY)
out_field  out  FIELD_W  key>>3 (KEY mode, else 0)
out_wire  out  3  key[2:0] (KEY mode, else 0)
out_nbytes  out  4  bytes consumed by this varint, saturating at 15
out_err  out  2  0=OK, 1=OVERFLOW, 2=TRUNC, 3=BAD_WIRE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE; accumulator, byte count and latched mode cleared; out_valid=0; out_value, out_field, out_wire, out_nbytes and out_err all 0. Reset mid-varint discards the partial word; there is no output for it.
- in_ready = !out_valid || out_ready (single output register, no skid). A byte and a result can transfer in the same cycle.
- States:
  - IDLE: no bytes of the current varint seen. An accepted byte latches mode, then goes to ACCUM, or emits directly if bit7=0.
  - ACCUM: accepted byte k (0-based) ORs data[6:0]<<(7k) into the accumulator. bit7=0 emits the result and returns to IDLE.
  - DRAIN: entered on overflow. Bytes are accepted and dropped until bit7=0 or in_last; then OVERFLOW is emitted and the state returns to IDLE.
- Latency: the terminating byte is accepted in cycle N; out_valid is asserted in cycle N+1. Fields hold stable while out_valid && !out_ready.
- Overflow has two triggers:
  - a byte is accepted with count==MAX_BYTES-1 and bit7=1;
  - any payload bit at position >=VALUE_W is nonzero. For VALUE_W=64, the 10th byte may only be 0x00 or 0x01.
  - Either trigger sets err=OVERFLOW and goes to DRAIN, or emits immediately if that byte already terminates. out_value is then 0.
- Truncation: in_last on a byte with bit7=1, outside DRAIN, emits err=TRUNC. out_value holds the partial accumulator.
- ZIGZAG: out_value = (acc>>1) ^ -(acc&1), computed at width VALUE_W.
- KEY: out_field = acc[FIELD_W+2:3]; out_wire = acc[2:0]. Wire type 6 or 7 gives err=BAD_WIRE, with the value still reported. Field number 0 also gives BAD_WIRE.
- Error precedence: OVERFLOW > TRUNC > BAD_WIRE.
- out_nbytes counts every accepted byte of the varint, including drained bytes.
- in_last with bit7=0 is a normal termination; it has no extra effect beyond resetting to IDLE.

Decomposition:
- pb_pkg gains:
  - a pb_varint_mode_e enum (RAW, ZIGZAG, KEY);
  - a pb_dec_err_e enum (OK, OVERFLOW, TRUNC, BAD_WIRE);
  - a wire_type_e enum (VARINT=0, I64=1, LEN=2, SGROUP=3, EGROUP=4, I32=5);
  - MAX_VARINT_BYTES.
- Sub-module pb_zigzag_decode: combinational and parametrised by VALUE_W. It is reused by future sint field extractors.

Test Plan:
- RAW: bytes 0x96,0x01 -> one result, out_value=150, out_nbytes=2, err=OK, out_valid the cycle after 0x01.
- ZIGZAG: 0x03 -> out_value=-2 (0xFFFF_FFFF_FFFF_FFFE). Then 0xFE,0xFF,0xFF,0xFF,0x0F -> 2147483647.
- KEY: 0x08 -> field=1, wire=0, OK. 0x12 -> field=2, wire=2. 0x0F -> wire=7, err=BAD_WIRE. 0x00 -> err=BAD_WIRE.
- Overflow: 0xFF×9 then 0x02 -> err=OVERFLOW, nbytes=10. 0xFF×11 then 0x00 -> single OVERFLOW result with nbytes=12, and the next varint 0x05 decodes as 5.
- Truncation and reset: 0x80 with in_last -> err=TRUNC, nbytes=1. Separately, 0x80 followed by rst pulse and then 0x01 -> only out_value=1 is produced.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0 and outputs stable. With out_ready=1, back-to-back single-byte varints -> one result per cycle with no bubbles.
